// File: rtl/cork_magazine_pkg.sv
// Shared encodings and widths for the cork magazine controller and its timeout timer.
package cork_magazine_pkg;
   localparam int CORK_W = 8;
   localparam int TMR_W  = 16;

   typedef enum logic [1:0] {
      S_STOCK   = 2'b00,
      S_REFILL  = 2'b01,
      S_FAULT   = 2'b10,
      S_ILLEGAL = 2'b11
   } state_t;
endpackage

// File: rtl/cork_magazine_timer.sv
// Saturating refill watchdog: counts cycles with no accepted cork, flags value == TIMEOUT-1.
module mag_timeout_timer
   import cork_magazine_pkg::*;
#(
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             run,
   output logic [TMR_W-1:0] value,
   output logic             expired
);
   localparam logic [TMR_W-1:0] L_LAST = TMR_W'(TIMEOUT - 1);

   logic [TMR_W-1:0] r_value;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_value <= '0;
      else if (clear)
         r_value <= '0;
      else if (run && (r_value != '1))
         r_value <= r_value + TMR_W'(1);
   end

   assign value   = r_value;
   assign expired = (r_value == L_LAST);
endmodule

// File: rtl/cork_magazine.sv
// Cork stock counter with feeder refill FSM and stall alarm; outputs decode from registers only.
// Optional usage/fault statistics ports when CORK_MAGAZINE_STATS_EN is defined.
module cork_magazine
   import cork_magazine_pkg::*;
#(
   parameter int MAX_CORKS = 200,
   parameter int LOW_LEVEL = 20,
   parameter int TIMEOUT   = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              consume,
   input  logic              cork_in_valid,
   input  logic              alarm_clr,
   output logic [CORK_W-1:0] rolha,
   output logic              cork_in_ready,
   output logic              refill_req,
   output logic              low,
   output logic              empty,
`ifdef CORK_MAGAZINE_STATS_EN
   output logic [15:0]       total_used,
   output logic [7:0]        fault_count,
`endif
   output logic              alarm
);
   localparam logic [CORK_W-1:0] L_MAX = CORK_W'(MAX_CORKS);
   localparam logic [CORK_W-1:0] L_LOW = CORK_W'(LOW_LEVEL);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CORK_W-1:0] r_count;
   logic [CORK_W-1:0] w_count_nxt;
   logic              w_cork_acc;
   logic              w_cons_acc;
   logic              w_tmr_clear;
   logic              w_tmr_run;
   logic              w_tmr_expired;
   logic [TMR_W-1:0]  w_tmr_value;

   assign cork_in_ready = (r_state != S_STOCK) && (r_count < L_MAX);
   assign refill_req    = (r_state != S_STOCK);
   assign alarm         = (r_state == S_FAULT);
   assign low           = (r_count <= L_LOW);
   assign empty         = (r_count == '0);
   assign rolha         = r_count;

   assign w_cork_acc = cork_in_valid && cork_in_ready;
   assign w_cons_acc = consume && (r_count != '0);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_cork_acc, w_cons_acc})
         2'b10:   w_count_nxt = r_count + CORK_W'(1);
         2'b01:   w_count_nxt = r_count - CORK_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_STOCK:  if (r_count <= L_LOW) w_state_nxt = S_REFILL;
         // Reaching full wins over a simultaneous timeout.
         S_REFILL: begin
            if (w_count_nxt == L_MAX)
               w_state_nxt = S_STOCK;
            else if (w_tmr_expired && !w_cork_acc)
               w_state_nxt = S_FAULT;
         end
         S_FAULT:  if (w_cork_acc || alarm_clr) w_state_nxt = S_REFILL;
         default:  w_state_nxt = S_STOCK;
      endcase
   end

   // Timer restarts on any entry into REFILL and on each accepted cork while refilling.
   assign w_tmr_clear = ((w_state_nxt == S_REFILL) && (r_state != S_REFILL))
                     || ((r_state == S_REFILL) && w_cork_acc);
   assign w_tmr_run   = (r_state == S_REFILL) && !w_cork_acc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_STOCK;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_count <= w_count_nxt;
      end
   end

   mag_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (w_tmr_clear),
      .run     (w_tmr_run),
      .value   (w_tmr_value),
      .expired (w_tmr_expired)
   );

`ifdef CORK_MAGAZINE_STATS_EN
   logic [15:0] r_total_used;
   logic [7:0]  r_fault_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_total_used  <= '0;
         r_fault_count <= '0;
      end else begin
         if (w_cons_acc)
            r_total_used <= r_total_used + 16'd1;
         if ((r_state == S_REFILL) && (w_state_nxt == S_FAULT) && (r_fault_count != 8'hFF))
            r_fault_count <= r_fault_count + 8'd1;
      end
   end

   assign total_used  = r_total_used;
   assign fault_count = r_fault_count;
`endif
endmodule

// File: tb/tb_cork_magazine.sv
// Directed bench for cork_magazine with MAX_CORKS=8, LOW_LEVEL=2, TIMEOUT=5.
module tb_cork_magazine;
   logic       clk = 1'b0;
   logic       reset;
   logic       consume;
   logic       cork_in_valid;
   logic       alarm_clr;
   logic [7:0] rolha;
   logic       cork_in_ready;
   logic       refill_req;
   logic       low;
   logic       empty;
   logic       alarm;
`ifdef CORK_MAGAZINE_STATS_EN
   logic [15:0] total_used;
   logic [7:0]  fault_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   cork_magazine #(
      .MAX_CORKS (8),
      .LOW_LEVEL (2),
      .TIMEOUT   (5)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .consume       (consume),
      .cork_in_valid (cork_in_valid),
      .alarm_clr     (alarm_clr),
      .rolha         (rolha),
      .cork_in_ready (cork_in_ready),
      .refill_req    (refill_req),
      .low           (low),
      .empty         (empty),
`ifdef CORK_MAGAZINE_STATS_EN
      .total_used    (total_used),
      .fault_count   (fault_count),
`endif
      .alarm         (alarm)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; consume = 1'b0; cork_in_valid = 1'b0; alarm_clr = 1'b0;
      @(negedge clk);
      check("rst_rolha", 32'(rolha), 0);
      check("rst_low", 32'(low), 1);
      check("rst_empty", 32'(empty), 1);
      check("rst_alarm", 32'(alarm), 0);
      check("rst_refill", 32'(refill_req), 0);
      check("rst_ready", 32'(cork_in_ready), 0);

      // 1: fill from empty with the feeder always offering
      reset = 1'b0;
      cork_in_valid = 1'b1;
      tick();
      check("t1_refill_entry", 32'(refill_req), 1);
      check("t1_rolha_entry", 32'(rolha), 0);
      for (int i = 1; i <= 8; i++) begin
         tick();
         check("t1_rolha", 32'(rolha), 32'(i));
      end
      check("t1_full_ready", 32'(cork_in_ready), 0);
      check("t1_full_refill", 32'(refill_req), 0);
      check("t1_full_low", 32'(low), 0);
      cork_in_valid = 1'b0;

      // 2: drain to the low mark
      consume = 1'b1;
      for (int i = 7; i >= 2; i--) begin
         tick();
         check("t2_rolha", 32'(rolha), 32'(i));
      end
      check("t2_low", 32'(low), 1);
      check("t2_refill_same", 32'(refill_req), 0);
      consume = 1'b0;
      tick();
      check("t2_refill_next", 32'(refill_req), 1);
      check("t2_rolha_hold", 32'(rolha), 2);

      // 3: simultaneous cork and consume at count 4
      cork_in_valid = 1'b1;
      tick();
      tick();
      check("t3_rolha_pre", 32'(rolha), 4);
      consume = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_rolha", 32'(rolha), 4);
         check("t3_timer", 32'(dut.w_tmr_value), 0);
         check("t3_alarm", 32'(alarm), 0);
      end
      consume = 1'b0;
      cork_in_valid = 1'b0;

      // 4: feeder stall raises the alarm after TIMEOUT idle cycles
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("t4_timer", 32'(dut.w_tmr_value), 32'(i));
         check("t4_alarm_pre", 32'(alarm), 0);
      end
      tick();
      check("t4_alarm", 32'(alarm), 1);
      check("t4_fault_refill", 32'(refill_req), 1);
      check("t4_fault_ready", 32'(cork_in_ready), 1);
`ifdef CORK_MAGAZINE_STATS_EN
      check("st_total_used", 32'(total_used), 9);
      check("st_fault_count", 32'(fault_count), 1);
`endif
      alarm_clr = 1'b1;
      tick();
      alarm_clr = 1'b0;
      check("t4_clr_alarm", 32'(alarm), 0);
      check("t4_clr_refill", 32'(refill_req), 1);
      check("t4_clr_timer", 32'(dut.w_tmr_value), 0);
      check("t4_clr_rolha", 32'(rolha), 4);

      // 6: asynchronous reset mid-refill at count 5
      cork_in_valid = 1'b1;
      tick();
      cork_in_valid = 1'b0;
      check("t6_rolha_pre", 32'(rolha), 5);
      #2 reset = 1'b1;
      #1;
      check("t6_async_rolha", 32'(rolha), 0);
      check("t6_async_alarm", 32'(alarm), 0);
      check("t6_async_refill", 32'(refill_req), 0);
      check("t6_async_empty", 32'(empty), 1);
      @(negedge clk);
      reset = 1'b0;
      check("t6_release_refill", 32'(refill_req), 0);
      tick();
      check("t6_resume_refill", 32'(refill_req), 1);

      // 5: consume at zero saturates
      consume = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t5_rolha", 32'(rolha), 0);
         check("t5_empty", 32'(empty), 1);
      end
      consume = 1'b0;
`ifdef CORK_MAGAZINE_STATS_EN
      check("st_total_after_rst", 32'(total_used), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
